// File: rtl/uc_upipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uc_upipe -- micro-instruction pipeline for the control unit.
//
// Carries each micro-instruction through STAGES registered stages. A bubble
// (NOP_U, valid low) is inserted wherever a hold or a flush needs one. A hold
// comes from the level request HOLD_REQ, or from a down-counter loaded by a
// HOLD_LD pulse. Holds inserted into the pipeline are counted in BUBBLE_CNT.
//
// Ports
//   CLK         in   clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   U_IN        in   [UW]   micro-instruction from the sequencer
//   U_IN_VALID  in          U_IN is meaningful
//   HOLD_REQ    in          level hold request from the hazard unit
//   HOLD_LD     in          one-cycle pulse: load the hold counter with HOLD_CYC
//   HOLD_CYC    in   [CW]   number of hold cycles to load
//   FLUSH       in          discard everything in flight
//   READY       out         U_IN is consumed at this edge
//   U_STG       out  [STAGES*UW] stage k at [k*UW +: UW], stage 0 youngest
//   V_STG       out  [STAGES]    per-stage valid bits
//   HOLD_BUSY   out         hold counter nonzero (FSM is in WAIT)
//   BUBBLE_CNT  out  [16]   saturating count of hold-inserted bubbles
//
// Handshake: the sequencer presents U_IN/U_IN_VALID; READY high means the edge
// that closes this cycle consumes U_IN. With READY low, stage 0 is frozen, so
// the sequencer must hold U_IN and U_IN_VALID steady until READY returns.
// -----------------------------------------------------------------------------
module uc_upipe #(
  parameter int              UW     = 34,
  parameter int              STAGES = 3,
  parameter int              CW     = 4,
  parameter logic [UW-1:0]   NOP_U  = {UW{1'b0}}
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [UW-1:0]          U_IN,
  input  logic                   U_IN_VALID,
  input  logic                   HOLD_REQ,
  input  logic                   HOLD_LD,
  input  logic [CW-1:0]          HOLD_CYC,
  input  logic                   FLUSH,
  output logic                   READY,
  output logic [STAGES*UW-1:0]   U_STG,
  output logic [STAGES-1:0]      V_STG,
  output logic                   HOLD_BUSY,
  output logic [15:0]            BUBBLE_CNT
);

  // Hold counter FSM. WAIT always coincides with cnt != 0, and HOLD_BUSY
  // is the externally visible copy of the state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hold_state_e;

  hold_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [UW-1:0]         u_q [STAGES];
  logic [UW-1:0]         u_d [STAGES];
  logic [STAGES-1:0]     v_q, v_d;
  logic [15:0]           bubble_q, bubble_d;
  logic                  hold_eff;

  assign hold_eff = HOLD_REQ | (cnt_q != '0);

  // ---------------------------------------------------------------------------
  // Hold counter next state. A load wins over the decrement; a flush wins
  // over everything, including a load in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (HOLD_LD) cnt_d = HOLD_CYC;
      end
      ST_WAIT: begin
        if (HOLD_LD) cnt_d = HOLD_CYC;
        else         cnt_d = cnt_q - CW'(1);
      end
      default: cnt_d = '0;
    endcase
    if (FLUSH) cnt_d = '0;
    // Loading zero, or decrementing from 1, lands back in IDLE.
    state_d = (cnt_d != '0) ? ST_WAIT : ST_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Pipeline next state. During a hold, stage 0 is frozen and the bubble is
  // injected into stage 1, so the older stages keep draining.
  // ---------------------------------------------------------------------------
  always_comb begin
    u_d      = u_q;
    v_d      = v_q;
    bubble_d = bubble_q;
    if (FLUSH) begin
      for (int k = 0; k < STAGES; k++) u_d[k] = NOP_U;
      v_d = '0;
    end else if (hold_eff) begin
      for (int k = STAGES - 1; k >= 2; k--) begin
        u_d[k] = u_q[k-1];
        v_d[k] = v_q[k-1];
      end
      u_d[1] = NOP_U;
      v_d[1] = 1'b0;
      if (bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
    end else begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        u_d[k] = u_q[k-1];
        v_d[k] = v_q[k-1];
      end
      u_d[0] = U_IN_VALID ? U_IN : NOP_U;
      v_d[0] = U_IN_VALID;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      v_q      <= '0;
      bubble_q <= '0;
      for (int k = 0; k < STAGES; k++) u_q[k] <= NOP_U;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
      bubble_q <= bubble_d;
      for (int k = 0; k < STAGES; k++) u_q[k] <= u_d[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    U_STG = '0;
    for (int k = 0; k < STAGES; k++) U_STG[k*UW +: UW] = u_q[k];
  end

  assign V_STG      = v_q;
  assign READY      = ~FLUSH & ~hold_eff;
  assign HOLD_BUSY  = (state_q == ST_WAIT);
  assign BUBBLE_CNT = bubble_q;

endmodule

// File: tb/tb_uc_upipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uc_upipe -- self-checking bench for uc_upipe.
// Reference model: stage contents in an array, hold counter and bubble count
// as plain integers, updated once per edge from the block's rules.
// -----------------------------------------------------------------------------
module tb_uc_upipe;

  localparam int            UW     = 34;
  localparam int            STAGES = 3;
  localparam int            CW     = 4;
  localparam logic [UW-1:0] NOP_U  = '0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [UW-1:0]        u_in = '0;
  logic                 u_in_valid = 1'b0;
  logic                 hold_req = 1'b0;
  logic                 hold_ld = 1'b0;
  logic [CW-1:0]        hold_cyc = '0;
  logic                 flush = 1'b0;
  logic                 ready;
  logic [STAGES*UW-1:0] u_stg;
  logic [STAGES-1:0]    v_stg;
  logic                 hold_busy;
  logic [15:0]          bubble_cnt;

  uc_upipe #(.UW(UW), .STAGES(STAGES), .CW(CW), .NOP_U(NOP_U)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .U_IN       (u_in),
    .U_IN_VALID (u_in_valid),
    .HOLD_REQ   (hold_req),
    .HOLD_LD    (hold_ld),
    .HOLD_CYC   (hold_cyc),
    .FLUSH      (flush),
    .READY      (ready),
    .U_STG      (u_stg),
    .V_STG      (v_stg),
    .HOLD_BUSY  (hold_busy),
    .BUBBLE_CNT (bubble_cnt)
  );

  // reference model state
  logic [UW-1:0] m_u [STAGES];
  bit            m_v [STAGES];
  int            m_cnt;
  int            m_bub;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------------------
  // scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [STAGES*UW-1:0] exp_ustg();
    logic [STAGES*UW-1:0] r;
    r = '0;
    for (int k = 0; k < STAGES; k++) r[k*UW +: UW] = m_u[k];
    return r;
  endfunction

  function automatic logic [STAGES-1:0] exp_vstg();
    logic [STAGES-1:0] r;
    r = '0;
    for (int k = 0; k < STAGES; k++) r[k] = m_v[k];
    return r;
  endfunction

  function automatic logic exp_ready();
    return !flush && !(hold_req || m_cnt != 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) begin
      m_u[k] = NOP_U;
      m_v[k] = 1'b0;
    end
    m_cnt = 0;
    m_bub = 0;
  endtask

  // One clock edge of the reference, using the inputs currently applied.
  task automatic model_edge();
    bit held;
    held = hold_req || (m_cnt != 0);
    if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        m_u[k] = NOP_U;
        m_v[k] = 1'b0;
      end
    end else if (held) begin
      for (int k = STAGES - 1; k >= 2; k--) begin
        m_u[k] = m_u[k-1];
        m_v[k] = m_v[k-1];
      end
      m_u[1] = NOP_U;
      m_v[1] = 1'b0;
      m_bub  = (m_bub >= 65535) ? 65535 : m_bub + 1;
    end else begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        m_u[k] = m_u[k-1];
        m_v[k] = m_v[k-1];
      end
      m_u[0] = u_in_valid ? u_in : NOP_U;
      m_v[0] = u_in_valid;
    end
    if (flush)            m_cnt = 0;
    else if (hold_ld)     m_cnt = int'(hold_cyc);
    else if (m_cnt > 0)   m_cnt = m_cnt - 1;
  endtask

  task automatic check_all(input string where);
    chk({where, ".u_stg"},  128'(u_stg),      128'(exp_ustg()));
    chk({where, ".v_stg"},  128'(v_stg),      128'(exp_vstg()));
    chk({where, ".busy"},   128'(hold_busy),  128'(m_cnt != 0));
    chk({where, ".bubble"}, 128'(bubble_cnt), 128'(m_bub));
    chk({where, ".ready"},  128'(ready),      128'(exp_ready()));
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [UW-1:0] u, input logic req,
                       input logic ld, input logic [CW-1:0] cyc, input logic fl);
    u_in_valid = v;
    u_in       = u;
    hold_req   = req;
    hold_ld    = ld;
    hold_cyc   = cyc;
    flush      = fl;
  endtask

  // Called 1ns after a rising edge with inputs freshly driven.
  task automatic cycle(input string where);
    #1;
    chk({where, ".ready_pre"}, 128'(ready), 128'(exp_ready()));
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  // watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    int need;
    logic [STAGES*UW-1:0] want;
    model_reset();

    // reset state, checked while reset is still asserted
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset_rel");

    // stream 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, UW'(i), 1'b0, 1'b0, '0, 1'b0);
      cycle("stream");
      if (i == 3) begin
        want = {34'd1, 34'd2, 34'd3};
        chk("stream.at3", 128'(u_stg), 128'(want));
        chk("stream.v3", 128'(v_stg), 128'(3'b111));
      end
    end

    // level hold with stage 0 = 5
    drive(1'b1, UW'(5), 1'b0, 1'b0, '0, 1'b0);
    cycle("pre_hold");
    base = m_bub;
    drive(1'b1, UW'(6), 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle("hold_req");
      chk("hold_req.s0", 128'(u_stg[0 +: UW]), 128'(5));
      chk("hold_req.v1", 128'(v_stg[1]), 128'(0));
    end
    chk("hold_req.bub", 128'(bubble_cnt), 128'(base + 2));
    drive(1'b1, UW'(6), 1'b0, 1'b0, '0, 1'b0);
    cycle("hold_rel");
    chk("hold_rel.s0", 128'(u_stg[0 +: UW]), 128'(6));

    // counted hold of 3
    drive(1'b1, UW'(7), 1'b0, 1'b1, CW'(3), 1'b0);
    cycle("ld3");
    chk("ld3.busy", 128'(hold_busy), 128'(1));
    base = m_bub;
    drive(1'b1, UW'(8), 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("ld3.wait");
    chk("ld3.bub", 128'(bubble_cnt), 128'(base + 3));
    chk("ld3.idle", 128'(hold_busy), 128'(0));
    cycle("ld3.adv");
    chk("ld3.s0", 128'(u_stg[0 +: UW]), 128'(8));

    // load of zero causes no hold
    drive(1'b1, UW'(9), 1'b0, 1'b1, CW'(0), 1'b0);
    cycle("ld0");
    chk("ld0.busy", 128'(hold_busy), 128'(0));
    chk("ld0.ready", 128'(ready), 128'(1));

    // reload 5 then 2: three hold edges in total
    base = m_bub;
    drive(1'b1, UW'(10), 1'b0, 1'b1, CW'(5), 1'b0);
    cycle("rld5");
    drive(1'b1, UW'(10), 1'b0, 1'b1, CW'(2), 1'b0);
    cycle("rld2");
    drive(1'b1, UW'(10), 1'b0, 1'b0, '0, 1'b0);
    cycle("rld.w1");
    cycle("rld.w2");
    chk("rld.bub", 128'(bubble_cnt), 128'(base + 3));
    chk("rld.busy", 128'(hold_busy), 128'(0));

    // flush together with a load
    drive(1'b1, UW'(11), 1'b0, 1'b1, CW'(7), 1'b1);
    cycle("flush_ld");
    chk("flush_ld.u", 128'(u_stg), 128'(0));
    chk("flush_ld.v", 128'(v_stg), 128'(0));
    chk("flush_ld.busy", 128'(hold_busy), 128'(0));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0),
            UW'({$urandom, $urandom}),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0),
            CW'($urandom_range(0, 15)),
            ($urandom_range(0, 39) == 0));
      cycle("rand");
    end

    // asynchronous reset while cnt = 4 and the pipeline is full
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    cycle("pre_rst.flush");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, UW'(20 + i), 1'b0, 1'b0, '0, 1'b0);
      cycle("pre_rst.fill");
    end
    drive(1'b1, UW'(23), 1'b0, 1'b1, CW'(4), 1'b0);
    cycle("pre_rst.ld");
    chk("pre_rst.full", 128'(v_stg), 128'(3'b111));
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("async_rst.u", 128'(u_stg), 128'(0));
    chk("async_rst.v", 128'(v_stg), 128'(0));
    chk("async_rst.busy", 128'(hold_busy), 128'(0));
    chk("async_rst.bub", 128'(bubble_cnt), 128'(0));
    model_reset();
    rst_n = 1'b1;
    check_all("async_rst.rel");

    // bubble counter saturation via a long level hold
    drive(1'b1, UW'(30), 1'b1, 1'b0, '0, 1'b0);
    need = 65534 - m_bub;
    for (int i = 0; i < need; i++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    chk("sat.65534", 128'(bubble_cnt), 128'(16'hFFFE));
    cycle("sat.a");
    chk("sat.ffff", 128'(bubble_cnt), 128'(16'hFFFF));
    cycle("sat.b");
    chk("sat.stay", 128'(bubble_cnt), 128'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
